// File: rtl/pll_cfg_ctrl_if.sv
// pll_cfg_ctrl_if: configuration request channel into the PLL sequencer.
// Signals: valid/ready handshake plus the requested dividers and park-in-bypass flag.
// Modports: master drives the request, slave (the sequencer) returns ready.
interface pll_cfg_ctrl_if;
  logic        valid;
  logic        ready;
  logic [7:0]  refdiv;
  logic [11:0] fbdiv;
  logic [3:0]  postdiv1;
  logic [1:0]  postdiv2;
  logic        bp;

  modport master (
    output valid, refdiv, fbdiv, postdiv1, postdiv2, bp,
    input  ready
  );

  modport slave (
    input  valid, refdiv, fbdiv, postdiv1, postdiv2, bp,
    output ready
  );
endinterface

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: sequences a PLL reprogram (mux to fref, load dividers, pulse PLL reset,
// wait for stable lock, mux back to PLL) and relocks automatically after lock loss in RUN.
// Latency: accept at edge N -> busy/clk_sel=0 after N; done_o after N+SW_CYC+RST_CYC+LOCK_STABLE+1.
// Backpressure: cfg.ready is high only in IDLE/RUN; requests while busy stall until then.
// Ports: clk_i/rst_i (sync, active high), cfg (request channel, slave modport),
//   pll_*_o (PLL pins), pll_lock_i, clk_sel_o (0=fref,1=PLL), busy_o, done_o,
//   lost_o/tmo_o (sticky errors), err_clr_i.
// Optional: define PLL_LOCK_TIMEOUT_EN to bound WAIT_LOCK to TIMEOUT_CYC cycles.
module pll_cfg_ctrl #(
  parameter int SW_CYC      = 4,
  parameter int RST_CYC     = 16,
  parameter int LOCK_STABLE = 32
`ifdef PLL_LOCK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 131071
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pll_cfg_ctrl_if.slave      cfg,
  output logic [7:0]         pll_refdiv_o,
  output logic [11:0]        pll_fbdiv_o,
  output logic [3:0]         pll_postdiv1_o,
  output logic [1:0]         pll_postdiv2_o,
  output logic               pll_bp_o,
  output logic               pll_rst_o,
  input  logic               pll_lock_i,
  output logic               clk_sel_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               lost_o,
  output logic               tmo_o,
  input  logic               err_clr_i
);

  // One phase counter is shared by BYPASS and RESET, so size it for the longer hold.
  localparam int PH_MAX = (SW_CYC > RST_CYC) ? SW_CYC : RST_CYC;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int LS_W   = $clog2(LOCK_STABLE) + 1;
  localparam logic [PH_W-1:0] SW_LAST  = PH_W'(SW_CYC - 1);
  localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYC - 1);
  localparam logic [LS_W-1:0] LS_LAST  = LS_W'(LOCK_STABLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BYPASS, S_RESET, S_WAIT_LOCK, S_SWITCH, S_RUN
  } state_t;

  state_t          state;
  logic [PH_W-1:0] ph_cnt;
  logic [LS_W-1:0] ls_cnt;
  logic [7:0]      req_refdiv;
  logic [11:0]     req_fbdiv;
  logic [3:0]      req_postdiv1;
  logic [1:0]      req_postdiv2;
  logic            req_bp;
  logic            cfg_ready;
  logic            accept;

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign tmo_o = 1'b0;
`endif

  assign cfg_ready = (state == S_IDLE) || (state == S_RUN);
  assign cfg.ready = cfg_ready;
  assign busy_o    = ~cfg_ready;
  assign accept    = cfg.valid & cfg_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      ph_cnt         <= '0;
      ls_cnt         <= '0;
      req_refdiv     <= '0;
      req_fbdiv      <= '0;
      req_postdiv1   <= '0;
      req_postdiv2   <= '0;
      req_bp         <= 1'b0;
      pll_refdiv_o   <= '0;
      pll_fbdiv_o    <= '0;
      pll_postdiv1_o <= '0;
      pll_postdiv2_o <= '0;
      pll_bp_o       <= 1'b1;
      pll_rst_o      <= 1'b1;
      clk_sel_o      <= 1'b0;
      done_o         <= 1'b0;
      lost_o         <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
      to_cnt         <= '0;
      tmo_o          <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      // Clears come first so a same-cycle set further down wins.
      if (err_clr_i) begin
        lost_o <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        tmo_o  <= 1'b0;
`endif
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            req_refdiv   <= cfg.refdiv;
            req_fbdiv    <= cfg.fbdiv;
            req_postdiv1 <= cfg.postdiv1;
            req_postdiv2 <= cfg.postdiv2;
            req_bp       <= cfg.bp;
            ph_cnt       <= '0;
            state        <= S_BYPASS;
          end
        end

        // Mux is already on fref; give it time to settle before disturbing the PLL.
        S_BYPASS: begin
          if (ph_cnt == SW_LAST) begin
            ph_cnt <= '0;
            if (req_bp) begin
              pll_bp_o  <= 1'b1;
              pll_rst_o <= 1'b1;
              done_o    <= 1'b1;
              state     <= S_IDLE;
            end else begin
              pll_refdiv_o   <= req_refdiv;
              pll_fbdiv_o    <= req_fbdiv;
              pll_postdiv1_o <= req_postdiv1;
              pll_postdiv2_o <= req_postdiv2;
              pll_bp_o       <= 1'b0;
              pll_rst_o      <= 1'b1;
              state          <= S_RESET;
            end
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        S_RESET: begin
          if (ph_cnt == RST_LAST) begin
            ph_cnt    <= '0;
            ls_cnt    <= '0;
            pll_rst_o <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            state     <= S_WAIT_LOCK;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        // Any low lock sample restarts the stability window.
        S_WAIT_LOCK: begin
          if (!pll_lock_i) begin
            ls_cnt <= '0;
          end else if (ls_cnt == LS_LAST) begin
            state <= S_SWITCH;
          end else begin
            ls_cnt <= ls_cnt + LS_W'(1);
          end
`ifdef PLL_LOCK_TIMEOUT_EN
          // A lock that completes on the expiry cycle still counts as success.
          if (!(pll_lock_i && (ls_cnt == LS_LAST))) begin
            if (to_cnt == TO_LAST) begin
              tmo_o     <= 1'b1;
              pll_bp_o  <= 1'b1;
              pll_rst_o <= 1'b1;
              clk_sel_o <= 1'b0;
              done_o    <= 1'b1;
              state     <= S_IDLE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
`endif
        end

        S_SWITCH: begin
          clk_sel_o <= 1'b1;
          done_o    <= 1'b1;
          state     <= S_RUN;
        end

        S_RUN: begin
          if (!pll_lock_i) begin
            lost_o <= 1'b1;
          end
          // An accepted request must be honoured, so it takes priority over relock.
          if (accept) begin
            req_refdiv   <= cfg.refdiv;
            req_fbdiv    <= cfg.fbdiv;
            req_postdiv1 <= cfg.postdiv1;
            req_postdiv2 <= cfg.postdiv2;
            req_bp       <= cfg.bp;
            ph_cnt       <= '0;
            clk_sel_o    <= 1'b0;
            state        <= S_BYPASS;
          end else if (!pll_lock_i) begin
            // Relock with the dividers already on the PLL pins.
            ph_cnt    <= '0;
            clk_sel_o <= 1'b0;
            pll_rst_o <= 1'b1;
            state     <= S_RESET;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb_pll_cfg_ctrl: directed, table-driven bench for pll_cfg_ctrl with default timing
// parameters (timeout limit 1024 when PLL_LOCK_TIMEOUT_EN is defined).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_pll_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll_lock;
  logic        err_clr;
  logic [7:0]  pll_refdiv;
  logic [11:0] pll_fbdiv;
  logic [3:0]  pll_postdiv1;
  logic [1:0]  pll_postdiv2;
  logic        pll_bp;
  logic        pll_rst;
  logic        clk_sel;
  logic        busy;
  logic        done;
  logic        lost;
  logic        tmo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_cfg_ctrl_if cfg_if ();

  pll_cfg_ctrl #(
`ifdef PLL_LOCK_TIMEOUT_EN
    .TIMEOUT_CYC(1024),
`endif
    .SW_CYC(4),
    .RST_CYC(16),
    .LOCK_STABLE(32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg            (cfg_if),
    .pll_refdiv_o   (pll_refdiv),
    .pll_fbdiv_o    (pll_fbdiv),
    .pll_postdiv1_o (pll_postdiv1),
    .pll_postdiv2_o (pll_postdiv2),
    .pll_bp_o       (pll_bp),
    .pll_rst_o      (pll_rst),
    .pll_lock_i     (pll_lock),
    .clk_sel_o      (clk_sel),
    .busy_o         (busy),
    .done_o         (done),
    .lost_o         (lost),
    .tmo_o          (tmo),
    .err_clr_i      (err_clr)
  );

  typedef struct {
    logic [7:0]  refdiv;
    logic [11:0] fbdiv;
    logic [3:0]  pd1;
    logic [1:0]  pd2;
    logic        bp;
    int          lat;
    logic [7:0]  e_ref;
    logic [11:0] e_fb;
    logic [3:0]  e_pd1;
    logic [1:0]  e_pd2;
    logic        e_bp;
    logic        e_sel;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts falling edges after the reference point until done_o is seen; -1 on expiry.
  // drop_k > 0 pulls lock low for the edge that follows sample k.
  task automatic wait_done(input int drop_k, input int lim, output int lat);
    lat = -1;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (drop_k > 0 && k == drop_k) pll_lock = 1'b0;
      if (drop_k > 0 && k == drop_k + 1) pll_lock = 1'b1;
    end
  endtask

  task automatic do_cfg(input logic [7:0] r, input logic [11:0] f, input logic [3:0] p1,
                        input logic [1:0] p2, input logic b, input int drop_k,
                        input int lim, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (cfg_if.ready !== 1'b1 && w < lim) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", 32'(cfg_if.ready), 32'd1);
    cfg_if.refdiv   = r;
    cfg_if.fbdiv    = f;
    cfg_if.postdiv1 = p1;
    cfg_if.postdiv2 = p2;
    cfg_if.bp       = b;
    cfg_if.valid    = 1'b1;
    @(negedge clk);
    cfg_if.valid = 1'b0;
    check("sel_after_accept", 32'(clk_sel), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(drop_k, lim, lat);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;

    vecs[0] = '{8'd1,   12'd50,  4'd2, 2'd1, 1'b0, 53, 8'd1,   12'd50,  4'd2, 2'd1, 1'b0, 1'b1};
    vecs[1] = '{8'd3,   12'hABC, 4'd7, 2'd3, 1'b0, 53, 8'd3,   12'hABC, 4'd7, 2'd3, 1'b0, 1'b1};
    vecs[2] = '{8'h55,  12'h123, 4'd9, 2'd2, 1'b1, 4,  8'd3,   12'hABC, 4'd7, 2'd3, 1'b1, 1'b0};
    vecs[3] = '{8'hFF,  12'hFFF, 4'hF, 2'd3, 1'b0, 53, 8'hFF,  12'hFFF, 4'hF, 2'd3, 1'b0, 1'b1};

    rst             = 1'b1;
    pll_lock        = 1'b1;
    err_clr         = 1'b0;
    cfg_if.valid    = 1'b0;
    cfg_if.refdiv   = '0;
    cfg_if.fbdiv    = '0;
    cfg_if.postdiv1 = '0;
    cfg_if.postdiv2 = '0;
    cfg_if.bp       = 1'b0;

    // Reset values with rst held for two edges.
    repeat (2) @(negedge clk);
    check("rst_refdiv", 32'(pll_refdiv), 32'd0);
    check("rst_fbdiv", 32'(pll_fbdiv), 32'd0);
    check("rst_pd1", 32'(pll_postdiv1), 32'd0);
    check("rst_pd2", 32'(pll_postdiv2), 32'd0);
    check("rst_bp", 32'(pll_bp), 32'd1);
    check("rst_pllrst", 32'(pll_rst), 32'd1);
    check("rst_sel", 32'(clk_sel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cfg_if.ready), 32'd1);
    rst = 1'b0;

    // Table: configs from IDLE, from RUN, park in bypass, all-ones dividers.
    for (int i = 0; i < 4; i++) begin
      do_cfg(vecs[i].refdiv, vecs[i].fbdiv, vecs[i].pd1, vecs[i].pd2, vecs[i].bp, 0, 300, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_refdiv", i), 32'(pll_refdiv), 32'(vecs[i].e_ref));
      check($sformatf("v%0d_fbdiv", i), 32'(pll_fbdiv), 32'(vecs[i].e_fb));
      check($sformatf("v%0d_pd1", i), 32'(pll_postdiv1), 32'(vecs[i].e_pd1));
      check($sformatf("v%0d_pd2", i), 32'(pll_postdiv2), 32'(vecs[i].e_pd2));
      check($sformatf("v%0d_pllbp", i), 32'(pll_bp), 32'(vecs[i].e_bp));
      check($sformatf("v%0d_pllrst", i), 32'(pll_rst), 32'(vecs[i].e_bp));
      check($sformatf("v%0d_sel", i), 32'(clk_sel), 32'(vecs[i].e_sel));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
    end

    // Lock glitch at stable count 31: window restarts, done 32 cycles later (53 -> 85).
    do_cfg(8'd2, 12'd100, 4'd1, 2'd2, 1'b0, 51, 300, lat);
    check("glitch_latency", 32'(lat), 32'd85);
    check("glitch_sel", 32'(clk_sel), 32'd1);

    // Lock loss in RUN: immediate fallback, sticky lost, relock with same dividers.
    @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    check("loss_sel", 32'(clk_sel), 32'd0);
    check("loss_lost", 32'(lost), 32'd1);
    check("loss_busy", 32'(busy), 32'd1);
    check("loss_pllrst", 32'(pll_rst), 32'd1);
    wait_done(0, 300, lat);
    check("relock_latency", 32'(lat), 32'd49);
    check("relock_sel", 32'(clk_sel), 32'd1);
    check("relock_fbdiv", 32'(pll_fbdiv), 32'd100);
    check("relock_lost_sticky", 32'(lost), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("errclr_lost", 32'(lost), 32'd0);

    // Clear and loss on the same cycle: the set wins.
    pll_lock = 1'b0;
    err_clr  = 1'b1;
    @(negedge clk);
    pll_lock = 1'b1;
    err_clr  = 1'b0;
    check("setwins_lost", 32'(lost), 32'd1);
    wait_done(0, 300, lat);
    check("setwins_relock", 32'(lat), 32'd49);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Lock never arrives.
    reset_dut();
    pll_lock = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
    do_cfg(8'd4, 12'd40, 4'd2, 2'd1, 1'b0, 0, 5000, lat);
    check("tmo_latency", 32'(lat), 32'd1044);
    check("tmo_flag", 32'(tmo), 32'd1);
    check("tmo_pllbp", 32'(pll_bp), 32'd1);
    check("tmo_pllrst", 32'(pll_rst), 32'd1);
    check("tmo_sel", 32'(clk_sel), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_clr", 32'(tmo), 32'd0);
`else
    do_cfg(8'd4, 12'd40, 4'd2, 2'd1, 1'b0, 0, 5000, lat);
    check("nolock_no_done", 32'(lat), 32'hFFFF_FFFF);
    check("nolock_busy", 32'(busy), 32'd1);
    check("nolock_pllrst", 32'(pll_rst), 32'd0);
    check("nolock_pllbp", 32'(pll_bp), 32'd0);
    check("nolock_sel", 32'(clk_sel), 32'd0);
    check("nolock_tmo", 32'(tmo), 32'd0);
`endif

    // Request during BYPASS stalls, reset during RESET aborts, held request then accepted.
    reset_dut();
    pll_lock = 1'b1;
    @(negedge clk);
    cfg_if.refdiv   = 8'd7;
    cfg_if.fbdiv    = 12'd77;
    cfg_if.postdiv1 = 4'd3;
    cfg_if.postdiv2 = 2'd1;
    cfg_if.bp       = 1'b0;
    cfg_if.valid    = 1'b1;
    @(negedge clk);
    cfg_if.valid = 1'b0;
    check("s6_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    cfg_if.refdiv   = 8'd9;
    cfg_if.fbdiv    = 12'd300;
    cfg_if.postdiv1 = 4'd5;
    cfg_if.postdiv2 = 2'd2;
    cfg_if.valid    = 1'b1;
    @(negedge clk);
    check("s6_stall_ready", 32'(cfg_if.ready), 32'd0);
    repeat (7) @(negedge clk);
    check("s6_in_reset_refdiv", 32'(pll_refdiv), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_abort_sel", 32'(clk_sel), 32'd0);
    check("s6_abort_pllbp", 32'(pll_bp), 32'd1);
    check("s6_abort_pllrst", 32'(pll_rst), 32'd1);
    check("s6_abort_refdiv", 32'(pll_refdiv), 32'd0);
    check("s6_abort_busy", 32'(busy), 32'd0);
    check("s6_abort_ready", 32'(cfg_if.ready), 32'd1);
    @(negedge clk);
    cfg_if.valid = 1'b0;
    check("s6_accept_busy", 32'(busy), 32'd1);
    wait_done(0, 300, lat);
    check("s6_latency", 32'(lat), 32'd53);
    check("s6_refdiv", 32'(pll_refdiv), 32'd9);
    check("s6_fbdiv", 32'(pll_fbdiv), 32'd300);
    check("s6_pd1", 32'(pll_postdiv1), 32'd5);
    check("s6_pd2", 32'(pll_postdiv2), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
